// File: rtl/key_ctrl_57_pkg.sv
// rtl/key_ctrl_57_pkg.sv - shared state and field-select encodings for the key controller
package key_ctrl_57_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_EDIT = 2'd1,
    ST_WEEK = 2'd2
  } state_t;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_SEC  = 3'b001;
  localparam logic [2:0] SEL_MIN  = 3'b010;
  localparam logic [2:0] SEL_HOUR = 3'b100;

  // sec -> min -> hour -> sec
  function automatic logic [2:0] rotate_sel(input logic [2:0] sel);
    return {sel[1:0], sel[2]};
  endfunction

endpackage

// File: rtl/key_debounce_57.sv
// rtl/key_debounce_57.sv - 2-FF synchroniser, stable-count debounce and one-cycle press pulse
module key_debounce_57 #(
  parameter int DEBOUNCE_CYC = 20
) (
  input  logic clk_57,
  input  logic rst_57,
  input  logic key_raw,
  output logic key_level,
  output logic key_press
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;
  logic          flip;

  // The DEBOUNCE_CYC-th consecutive differing cycle flips the level instead of counting on
  assign flip = (sync_q2 != key_level) && (cnt == CW'(DEBOUNCE_CYC - 1));

  always_ff @(posedge clk_57) begin
    if (rst_57) begin
      sync_q1   <= 1'b0;
      sync_q2   <= 1'b0;
      cnt       <= '0;
      key_level <= 1'b0;
      key_press <= 1'b0;
    end else begin
      sync_q1   <= key_raw;
      sync_q2   <= sync_q1;
      key_press <= flip && !key_level;
      if (sync_q2 == key_level) begin
        cnt <= '0;
      end else if (flip) begin
        cnt       <= '0;
        key_level <= ~key_level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_ctrl_57.sv
// rtl/key_ctrl_57.sv - front-panel key debounce, mode/edit FSM and up-key auto-repeat
module key_ctrl_57
  import key_ctrl_57_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 20,
  parameter int REPEAT_DLY   = 500,
  parameter int REPEAT_PER   = 100
) (
  input  logic       clk_57,
  input  logic       rst_57,
  input  logic       key_mode_57,
  input  logic       key_next_57,
  input  logic       key_up_57,
  output logic       time_model_57,
  output logic       shine_e_57,
  output logic [2:0] select_57,
  output logic       week_e_57,
  output logic       inc_sec_57,
  output logic       inc_min_57,
  output logic       inc_hour_57
);

  localparam int HW = $clog2(REPEAT_DLY + 1);
  localparam int PW = $clog2(REPEAT_PER + 1);

  logic mode_level, mode_press;
  logic next_level, next_press;
  logic up_level, up_press;
  logic unused_levels;

  key_debounce_57 #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode (
    .clk_57(clk_57), .rst_57(rst_57), .key_raw(key_mode_57),
    .key_level(mode_level), .key_press(mode_press)
  );

  key_debounce_57 #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_next (
    .clk_57(clk_57), .rst_57(rst_57), .key_raw(key_next_57),
    .key_level(next_level), .key_press(next_press)
  );

  key_debounce_57 #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_up (
    .clk_57(clk_57), .rst_57(rst_57), .key_raw(key_up_57),
    .key_level(up_level), .key_press(up_press)
  );

  // Only the up key needs its held level (for auto-repeat)
  assign unused_levels = mode_level ^ next_level;

  state_t        state_q, state_d;
  logic [2:0]    sel_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [PW-1:0] per_q, per_d;
  logic          rep_fire;
  logic          up_ev;

  always_ff @(posedge clk_57) begin
    if (rst_57) begin
      state_q       <= ST_RUN;
      hold_q        <= '0;
      per_q         <= '0;
      time_model_57 <= 1'b1;
      shine_e_57    <= 1'b0;
      select_57     <= SEL_NONE;
      week_e_57     <= 1'b0;
      inc_sec_57    <= 1'b0;
      inc_min_57    <= 1'b0;
      inc_hour_57   <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      per_q         <= per_d;
      time_model_57 <= (state_d != ST_WEEK);
      shine_e_57    <= (state_d == ST_EDIT);
      select_57     <= sel_d;
      week_e_57     <= (state_d == ST_WEEK);
      inc_sec_57    <= up_ev && (select_57 == SEL_SEC);
      inc_min_57    <= up_ev && (select_57 == SEL_MIN);
      inc_hour_57   <= up_ev && (select_57 == SEL_HOUR);
    end
  end

  // hold_q tracks the hold offset from the press; once it parks at REPEAT_DLY, per_q paces repeats
  assign rep_fire = up_level && (hold_q == HW'(REPEAT_DLY)) && (per_q == '0);

  always_comb begin
    state_d = state_q;
    sel_d   = select_57;
    hold_d  = hold_q;
    per_d   = per_q;
    up_ev   = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (mode_press) begin
          state_d = ST_EDIT;
          sel_d   = SEL_SEC;
        end
      end
      ST_EDIT: begin
        if (mode_press) begin
          state_d = ST_WEEK;
          sel_d   = SEL_NONE;
        end else begin
          up_ev = up_press || rep_fire;
          if (next_press) begin
            sel_d = rotate_sel(select_57);
          end
        end
      end
      ST_WEEK: begin
        if (mode_press) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        sel_d   = SEL_NONE;
      end
    endcase

    if ((state_d != ST_EDIT) || !up_level) begin
      hold_d = '0;
      per_d  = '0;
    end else if ((state_q == ST_EDIT) && up_press) begin
      hold_d = HW'(1);
      per_d  = '0;
    end else if (hold_q != '0) begin
      if (hold_q != HW'(REPEAT_DLY)) begin
        hold_d = hold_q + 1'b1;
      end else if (per_q == PW'(REPEAT_PER - 1)) begin
        per_d = '0;
      end else begin
        per_d = per_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_key_ctrl_57.sv
// tb/tb_key_ctrl_57.sv - directed, table-driven self-checking bench for key_ctrl_57
module tb_key_ctrl_57;

  logic       clk_57 = 1'b0;
  logic       rst_57 = 1'b1;
  logic       key_mode_57 = 1'b0;
  logic       key_next_57 = 1'b0;
  logic       key_up_57 = 1'b0;
  logic       time_model_57;
  logic       shine_e_57;
  logic [2:0] select_57;
  logic       week_e_57;
  logic       inc_sec_57;
  logic       inc_min_57;
  logic       inc_hour_57;

  key_ctrl_57 #(.DEBOUNCE_CYC(4), .REPEAT_DLY(10), .REPEAT_PER(3)) dut (
    .clk_57(clk_57), .rst_57(rst_57),
    .key_mode_57(key_mode_57), .key_next_57(key_next_57), .key_up_57(key_up_57),
    .time_model_57(time_model_57), .shine_e_57(shine_e_57), .select_57(select_57),
    .week_e_57(week_e_57), .inc_sec_57(inc_sec_57), .inc_min_57(inc_min_57),
    .inc_hour_57(inc_hour_57)
  );

  always #5 clk_57 = ~clk_57;

  // {time_model, shine_e, select[2:0], week_e}
  localparam logic [5:0] O_RUN  = 6'b1_0_000_0;
  localparam logic [5:0] O_E001 = 6'b1_1_001_0;
  localparam logic [5:0] O_E010 = 6'b1_1_010_0;
  localparam logic [5:0] O_E100 = 6'b1_1_100_0;
  localparam logic [5:0] O_WEEK = 6'b0_0_000_1;

  typedef struct {
    string      name;
    logic       m;
    logic       n;
    logic       u;
    logic [5:0] exp_outs;
    int         exp_sec;
    int         exp_min;
    int         exp_hour;
  } vec_t;

  vec_t vecs[13];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cnt_sec, cnt_min, cnt_hour;
  int   viol = 0;
  logic prev_inc = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int outs();
    return int'({time_model_57, shine_e_57, select_57, week_e_57});
  endfunction

  task automatic tick_count();
    @(negedge clk_57);
    cnt_sec  += int'(inc_sec_57);
    cnt_min  += int'(inc_min_57);
    cnt_hour += int'(inc_hour_57);
  endtask

  task automatic clear_counts();
    cnt_sec = 0;
    cnt_min = 0;
    cnt_hour = 0;
  endtask

  task automatic press(input logic m, input logic n, input logic u, input int hold);
    key_mode_57 = m;
    key_next_57 = n;
    key_up_57   = u;
    repeat (hold) tick_count();
    key_mode_57 = 1'b0;
    key_next_57 = 1'b0;
    key_up_57   = 1'b0;
    repeat (14) tick_count();
  endtask

  task automatic run_vec(input int i);
    clear_counts();
    press(vecs[i].m, vecs[i].n, vecs[i].u, 8);
    check({vecs[i].name, "_outs"}, outs(), int'(vecs[i].exp_outs));
    check({vecs[i].name, "_sec"}, cnt_sec, vecs[i].exp_sec);
    check({vecs[i].name, "_min"}, cnt_min, vecs[i].exp_min);
    check({vecs[i].name, "_hour"}, cnt_hour, vecs[i].exp_hour);
  endtask

  always @(negedge clk_57) begin
    if ((int'(inc_sec_57) + int'(inc_min_57) + int'(inc_hour_57)) > 1) viol++;
    if (prev_inc && (inc_sec_57 || inc_min_57 || inc_hour_57)) viol++;
    prev_inc = inc_sec_57 | inc_min_57 | inc_hour_57;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   found;
    int   npulse;
    logic [31:0] mask;

    vecs[0]  = '{"next_to_min",   1'b0, 1'b1, 1'b0, O_E010, 0, 0, 0};
    vecs[1]  = '{"up_at_min",     1'b0, 1'b0, 1'b1, O_E010, 0, 1, 0};
    vecs[2]  = '{"next_to_hour",  1'b0, 1'b1, 1'b0, O_E100, 0, 0, 0};
    vecs[3]  = '{"next_to_sec",   1'b0, 1'b1, 1'b0, O_E001, 0, 0, 0};
    vecs[4]  = '{"up_at_sec",     1'b0, 1'b0, 1'b1, O_E001, 1, 0, 0};
    vecs[5]  = '{"next_min2",     1'b0, 1'b1, 1'b0, O_E010, 0, 0, 0};
    vecs[6]  = '{"next_hour2",    1'b0, 1'b1, 1'b0, O_E100, 0, 0, 0};
    vecs[7]  = '{"mode_to_week",  1'b1, 1'b0, 1'b0, O_WEEK, 0, 0, 0};
    vecs[8]  = '{"week_up",       1'b0, 1'b0, 1'b1, O_WEEK, 0, 0, 0};
    vecs[9]  = '{"week_next",     1'b0, 1'b1, 1'b0, O_WEEK, 0, 0, 0};
    vecs[10] = '{"mode_to_run",   1'b1, 1'b0, 1'b0, O_RUN,  0, 0, 0};
    vecs[11] = '{"mode_to_edit",  1'b1, 1'b0, 1'b0, O_E001, 0, 0, 0};
    vecs[12] = '{"next_up_same",  1'b0, 1'b1, 1'b1, O_E010, 1, 0, 0};

    rst_57 = 1'b1;
    repeat (3) @(negedge clk_57);
    rst_57 = 1'b0;
    @(negedge clk_57);
    check("reset_outs", outs(), int'(O_RUN));
    check("reset_inc", int'({inc_sec_57, inc_min_57, inc_hour_57}), 0);
    repeat (5) @(negedge clk_57);

    // Three-cycle glitch on mode must be filtered out
    key_mode_57 = 1'b1;
    repeat (3) @(negedge clk_57);
    key_mode_57 = 1'b0;
    repeat (12) @(negedge clk_57);
    check("glitch_outs", outs(), int'(O_RUN));

    // Held mode rise: EDIT appears exactly 7 cycles after the raw edge
    key_mode_57 = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk_57);
      if (k == 6) check("latency_cyc6_shine", int'(shine_e_57), 0);
      if (k == 7) check("latency_cyc7_outs", outs(), int'(O_E001));
    end
    key_mode_57 = 1'b0;
    repeat (14) @(negedge clk_57);

    for (int i = 0; i <= 6; i++) run_vec(i);

    // Hold up at select=100: pulses at offsets 0,10,13,16,19 from the first pulse
    clear_counts();
    key_up_57 = 1'b1;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge clk_57);
      if (inc_hour_57) found = 1;
    end
    check("repeat_first_seen", found, 1);
    mask = 32'h1;
    npulse = 1;
    for (int i = 1; i < 40; i++) begin
      @(negedge clk_57);
      if (inc_hour_57) begin
        npulse++;
        if (i < 32) mask[i] = 1'b1;
      end
      cnt_sec += int'(inc_sec_57);
      cnt_min += int'(inc_min_57);
      if (i == 14) key_up_57 = 1'b0;
    end
    check("repeat_offsets", int'(mask), int'((32'h1 << 0) | (32'h1 << 10) | (32'h1 << 13) | (32'h1 << 16) | (32'h1 << 19)));
    check("repeat_count", npulse, 5);
    check("repeat_other_inc", cnt_sec + cnt_min, 0);
    check("repeat_outs", outs(), int'(O_E100));

    for (int i = 7; i <= 12; i++) run_vec(i);

    // Reset while up is held in EDIT (select=010)
    key_up_57 = 1'b1;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge clk_57);
      if (inc_min_57) found = 1;
    end
    check("rst_hold_first_seen", found, 1);
    repeat (3) @(negedge clk_57);
    rst_57 = 1'b1;
    @(negedge clk_57);
    check("rst_mid_outs", outs(), int'(O_RUN));
    check("rst_mid_inc", int'({inc_sec_57, inc_min_57, inc_hour_57}), 0);
    repeat (2) @(negedge clk_57);
    rst_57 = 1'b0;
    clear_counts();
    repeat (30) tick_count();
    check("after_rst_inc", cnt_sec + cnt_min + cnt_hour, 0);
    check("after_rst_outs", outs(), int'(O_RUN));
    key_up_57 = 1'b0;
    repeat (10) @(negedge clk_57);

    check("inc_exclusive", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
